// File: rtl/encap_tunnel_lookup_pkg.sv
// Shared widths, entry layout, FSM encoding and payload types for the encap tunnel lookup engine.
// Optional statistics counters are enabled with TUNNEL_LOOKUP_STATS_EN.
package encap_tunnel_lookup_pkg;

  localparam int unsigned TUNNEL_HASH_TABLE_DEPTH_NBITS = 10;
  localparam int unsigned TUNNEL_HASH_BUCKET_NBITS      = 192;
  localparam int unsigned TUNNEL_VALUE_NBITS            = 64;
  localparam int unsigned TUNNEL_VALUE_DEPTH_NBITS      = 8;
  localparam int unsigned TUNNEL_KEY_NBITS              = 32;
  localparam int unsigned TUNNEL_BUCKET_ENTRIES         = 4;

  localparam int unsigned DEPTH_NBITS       = TUNNEL_HASH_TABLE_DEPTH_NBITS;
  localparam int unsigned BUCKET_NBITS      = TUNNEL_HASH_BUCKET_NBITS;
  localparam int unsigned VALUE_NBITS       = TUNNEL_VALUE_NBITS;
  localparam int unsigned VALUE_DEPTH_NBITS = TUNNEL_VALUE_DEPTH_NBITS;
  localparam int unsigned KEY_NBITS         = TUNNEL_KEY_NBITS;
  localparam int unsigned ENTRIES           = TUNNEL_BUCKET_ENTRIES;
  localparam int unsigned ENTRY_NBITS       = BUCKET_NBITS / ENTRIES;
  localparam int unsigned ENTRY_IDX_NBITS   = $clog2(ENTRIES);
  localparam int unsigned STAT_NBITS        = 32;

  // Entry field offsets: valid at the MSB, ptr at the LSBs, key just above ptr.
  localparam int unsigned ENTRY_PTR_LSB   = 0;
  localparam int unsigned ENTRY_KEY_LSB   = ENTRY_PTR_LSB + VALUE_DEPTH_NBITS;
  localparam int unsigned ENTRY_VALID_BIT = ENTRY_NBITS - 1;
  localparam int unsigned ENTRY_RSVD_NBITS = ENTRY_VALID_BIT - (ENTRY_KEY_LSB + KEY_NBITS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HT_RD    = 3'd1,
    ST_HT_WAIT  = 3'd2,
    ST_MATCH    = 3'd3,
    ST_VAL_RD   = 3'd4,
    ST_VAL_WAIT = 3'd5,
    ST_RESP     = 3'd6
  } state_t;

  typedef struct packed {
    logic                         valid;
    logic [ENTRY_RSVD_NBITS-1:0]  rsvd;
    logic [KEY_NBITS-1:0]         key;
    logic [VALUE_DEPTH_NBITS-1:0] ptr;
  } tunnel_entry_t;

  typedef struct packed {
    logic [KEY_NBITS-1:0]   key;
    logic [DEPTH_NBITS-1:0] hash0;
    logic [DEPTH_NBITS-1:0] hash1;
  } lookup_req_t;

  function automatic logic entry_match(input tunnel_entry_t e, input logic [KEY_NBITS-1:0] key);
    return e.valid && (e.key == key);
  endfunction

endpackage

// File: rtl/encap_tunnel_lookup_bucket_match.sv
// Combinational key match across all entries of one hash bucket; the lowest matching entry wins.
// Module name kept as encap_tunnel_bucket_match so both banks share one instance type.
module encap_tunnel_bucket_match
  import encap_tunnel_lookup_pkg::*;
(
  input  logic [BUCKET_NBITS-1:0]      bucket,
  input  logic [KEY_NBITS-1:0]         key,
  output logic                         hit,
  output logic [ENTRY_IDX_NBITS-1:0]   idx,
  output logic [VALUE_DEPTH_NBITS-1:0] ptr
);

  tunnel_entry_t [ENTRIES-1:0] entries;
  logic unused_rsvd;

  assign entries = bucket;

  // Scan high to low so the lowest-index match is the last one written.
  always_comb begin
    hit         = 1'b0;
    idx         = '0;
    ptr         = '0;
    unused_rsvd = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      unused_rsvd = unused_rsvd ^ (^entries[i].rsvd);
      if (entry_match(entries[i], key)) begin
        hit = 1'b1;
        idx = ENTRY_IDX_NBITS'(i);
        ptr = entries[i].ptr;
      end
    end
  end

endmodule

// File: rtl/encap_tunnel_lookup.sv
// Tunnel lookup engine: reads both hash banks, matches the key, fetches the value record.
// Define TUNNEL_LOOKUP_STATS_EN to add saturating hit/miss result counters.
module encap_tunnel_lookup
  import encap_tunnel_lookup_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lookup_valid,
  output logic                         lookup_ready,
  input  logic [KEY_NBITS-1:0]         lookup_key,
  input  logic [DEPTH_NBITS-1:0]       lookup_hash0,
  input  logic [DEPTH_NBITS-1:0]       lookup_hash1,
  output logic                         tunnel_hash_table0_rd,
  output logic [DEPTH_NBITS-1:0]       tunnel_hash_table0_raddr,
  input  logic                         tunnel_hash_table0_ack,
  input  logic [BUCKET_NBITS-1:0]      tunnel_hash_table0_rdata,
  output logic                         tunnel_hash_table1_rd,
  output logic [DEPTH_NBITS-1:0]       tunnel_hash_table1_raddr,
  input  logic                         tunnel_hash_table1_ack,
  input  logic [BUCKET_NBITS-1:0]      tunnel_hash_table1_rdata,
  output logic                         tunnel_value_rd,
  output logic [VALUE_DEPTH_NBITS-1:0] tunnel_value_raddr,
  input  logic                         tunnel_value_ack,
  input  logic [VALUE_NBITS-1:0]       tunnel_value_rdata,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         result_hit,
  output logic [VALUE_NBITS-1:0]       result_value
`ifdef TUNNEL_LOOKUP_STATS_EN
  ,
  output logic [STAT_NBITS-1:0]        stat_hit_cnt,
  output logic [STAT_NBITS-1:0]        stat_miss_cnt
`endif
);

  state_t                       state_q;
  state_t                       state_d;
  lookup_req_t                  req_q;
  logic [BUCKET_NBITS-1:0]      bucket0_q;
  logic [BUCKET_NBITS-1:0]      bucket1_q;
  logic                         cap0_q;
  logic                         cap1_q;
  logic [VALUE_DEPTH_NBITS-1:0] ptr_q;

  logic                         got0_c;
  logic                         got1_c;
  logic                         accept_c;

  logic                         ready_d;
  logic                         ht_rd_d;
  logic                         val_rd_d;
  logic                         res_valid_d;

  logic                         m0_hit;
  logic                         m1_hit;
  logic [ENTRY_IDX_NBITS-1:0]   m0_idx;
  logic [ENTRY_IDX_NBITS-1:0]   m1_idx;
  logic [VALUE_DEPTH_NBITS-1:0] m0_ptr;
  logic [VALUE_DEPTH_NBITS-1:0] m1_ptr;
  logic                         unused_idx;

  encap_tunnel_bucket_match u_match0 (
    .bucket (bucket0_q),
    .key    (req_q.key),
    .hit    (m0_hit),
    .idx    (m0_idx),
    .ptr    (m0_ptr)
  );

  encap_tunnel_bucket_match u_match1 (
    .bucket (bucket1_q),
    .key    (req_q.key),
    .hit    (m1_hit),
    .idx    (m1_idx),
    .ptr    (m1_ptr)
  );

  assign unused_idx = ^{m0_idx, m1_idx};

  assign accept_c = (state_q == ST_IDLE) && lookup_valid && lookup_ready;
  assign got0_c   = cap0_q | tunnel_hash_table0_ack;
  assign got1_c   = cap1_q | tunnel_hash_table1_ack;

  assign tunnel_hash_table0_raddr = req_q.hash0;
  assign tunnel_hash_table1_raddr = req_q.hash1;
  assign tunnel_value_raddr       = ptr_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept_c) state_d = ST_HT_RD;
      ST_HT_RD:    state_d = ST_HT_WAIT;
      ST_HT_WAIT:  if (got0_c && got1_c) state_d = ST_MATCH;
      ST_MATCH:    state_d = (m0_hit || m1_hit) ? ST_VAL_RD : ST_RESP;
      ST_VAL_RD:   state_d = ST_VAL_WAIT;
      ST_VAL_WAIT: if (tunnel_value_ack) state_d = ST_RESP;
      ST_RESP:     if (result_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    ht_rd_d     = (state_d == ST_HT_RD);
    val_rd_d    = (state_d == ST_VAL_RD);
    res_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_ready          <= 1'b0;
      tunnel_hash_table0_rd <= 1'b0;
      tunnel_hash_table1_rd <= 1'b0;
      tunnel_value_rd       <= 1'b0;
      result_valid          <= 1'b0;
    end else begin
      lookup_ready          <= ready_d;
      tunnel_hash_table0_rd <= ht_rd_d;
      tunnel_hash_table1_rd <= ht_rd_d;
      tunnel_value_rd       <= val_rd_d;
      result_valid          <= res_valid_d;
    end
  end

  // Request latch and per-bank bucket capture; a bank's first ack in HT_WAIT wins, repeats are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      bucket0_q <= '0;
      bucket1_q <= '0;
      cap0_q    <= 1'b0;
      cap1_q    <= 1'b0;
    end else begin
      if (accept_c) begin
        req_q <= '{key: lookup_key, hash0: lookup_hash0, hash1: lookup_hash1};
      end
      if (state_q == ST_HT_RD) begin
        cap0_q <= 1'b0;
        cap1_q <= 1'b0;
      end
      if (state_q == ST_HT_WAIT) begin
        if (tunnel_hash_table0_ack && !cap0_q) begin
          bucket0_q <= tunnel_hash_table0_rdata;
          cap0_q    <= 1'b1;
        end
        if (tunnel_hash_table1_ack && !cap1_q) begin
          bucket1_q <= tunnel_hash_table1_rdata;
          cap1_q    <= 1'b1;
        end
      end
    end
  end

  // Winning pointer and result payload; payload only changes outside RESP so it is stable while valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      result_hit   <= 1'b0;
      result_value <= '0;
    end else begin
      if (state_q == ST_MATCH) begin
        if (m0_hit) begin
          ptr_q <= m0_ptr;
        end else if (m1_hit) begin
          ptr_q <= m1_ptr;
        end else begin
          result_hit   <= 1'b0;
          result_value <= '0;
        end
      end
      if ((state_q == ST_VAL_WAIT) && tunnel_value_ack) begin
        result_hit   <= 1'b1;
        result_value <= tunnel_value_rdata;
      end
    end
  end

`ifdef TUNNEL_LOOKUP_STATS_EN
  // Saturating counters, one count per result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (result_valid && result_ready) begin
      if (result_hit) begin
        if (stat_hit_cnt != '1) stat_hit_cnt <= stat_hit_cnt + STAT_NBITS'(1);
      end else begin
        if (stat_miss_cnt != '1) stat_miss_cnt <= stat_miss_cnt + STAT_NBITS'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_encap_tunnel_lookup.sv
// Scoreboard bench for encap_tunnel_lookup with behavioural hash-bank and value memories.
module tb_encap_tunnel_lookup;
  import encap_tunnel_lookup_pkg::*;

  logic                         clk;
  logic                         rst;
  logic                         lookup_valid;
  logic                         lookup_ready;
  logic [KEY_NBITS-1:0]         lookup_key;
  logic [DEPTH_NBITS-1:0]       lookup_hash0;
  logic [DEPTH_NBITS-1:0]       lookup_hash1;
  logic                         ht0_rd;
  logic [DEPTH_NBITS-1:0]       ht0_raddr;
  logic                         ht0_ack;
  logic [BUCKET_NBITS-1:0]      ht0_rdata;
  logic                         ht1_rd;
  logic [DEPTH_NBITS-1:0]       ht1_raddr;
  logic                         ht1_ack;
  logic [BUCKET_NBITS-1:0]      ht1_rdata;
  logic                         val_rd;
  logic [VALUE_DEPTH_NBITS-1:0] val_raddr;
  logic                         val_ack;
  logic [VALUE_NBITS-1:0]       val_rdata;
  logic                         result_valid;
  logic                         result_ready;
  logic                         result_hit;
  logic [VALUE_NBITS-1:0]       result_value;
`ifdef TUNNEL_LOOKUP_STATS_EN
  logic [31:0]                  stat_hit_cnt;
  logic [31:0]                  stat_miss_cnt;
`endif

  encap_tunnel_lookup dut (
    .clk                      (clk),
    .rst                      (rst),
    .lookup_valid             (lookup_valid),
    .lookup_ready             (lookup_ready),
    .lookup_key               (lookup_key),
    .lookup_hash0             (lookup_hash0),
    .lookup_hash1             (lookup_hash1),
    .tunnel_hash_table0_rd    (ht0_rd),
    .tunnel_hash_table0_raddr (ht0_raddr),
    .tunnel_hash_table0_ack   (ht0_ack),
    .tunnel_hash_table0_rdata (ht0_rdata),
    .tunnel_hash_table1_rd    (ht1_rd),
    .tunnel_hash_table1_raddr (ht1_raddr),
    .tunnel_hash_table1_ack   (ht1_ack),
    .tunnel_hash_table1_rdata (ht1_rdata),
    .tunnel_value_rd          (val_rd),
    .tunnel_value_raddr       (val_raddr),
    .tunnel_value_ack         (val_ack),
    .tunnel_value_rdata       (val_rdata),
    .result_valid             (result_valid),
    .result_ready             (result_ready),
    .result_hit               (result_hit),
    .result_value             (result_value)
`ifdef TUNNEL_LOOKUP_STATS_EN
    ,
    .stat_hit_cnt             (stat_hit_cnt),
    .stat_miss_cnt            (stat_miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [63:0] value;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  addr_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          done_cnt = 0;
  bit          first_seen = 1'b0;

  logic [191:0] mem_b0, mem_b1;
  logic [9:0]   cur_h0, cur_h1;
  int           dly0 = 1, dly1 = 1, dlyv = 1;
  int           pend0 = 0, pend1 = 0, pendv = 0;
  logic [7:0]   vaddr_lat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic logic [63:0] val_of(input logic [7:0] a);
    return 64'hC0DE_0000_0000_0000 | {40'h0, a, 8'h00, a};
  endfunction

  function automatic logic [47:0] mk_entry(input logic v, input logic [31:0] k, input logic [7:0] p);
    return {v, 7'h55, k, p};
  endfunction

  function automatic logic [191:0] filler(input logic [7:0] seed);
    return {mk_entry(1'b1, 32'hDEAD_0003, seed + 8'd3), mk_entry(1'b1, 32'hDEAD_0002, seed + 8'd2),
            mk_entry(1'b1, 32'hDEAD_0001, seed + 8'd1), mk_entry(1'b1, 32'hDEAD_0000, seed)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: drives acks a programmable number of cycles after each read pulse.
  always @(posedge clk) begin
    #1;
    ht0_ack = 1'b0;
    ht1_ack = 1'b0;
    val_ack = 1'b0;
    if (pend0 > 0) begin pend0--; if (pend0 == 0) begin ht0_ack = 1'b1; ht0_rdata = mem_b0; end end
    if (pend1 > 0) begin pend1--; if (pend1 == 0) begin ht1_ack = 1'b1; ht1_rdata = mem_b1; end end
    if (pendv > 0) begin pendv--; if (pendv == 0) begin val_ack = 1'b1; val_rdata = val_of(vaddr_lat); end end
    if (ht0_rd) begin pend0 = dly0; check("ht0_raddr", 64'(ht0_raddr), 64'(cur_h0)); end
    if (ht1_rd) begin pend1 = dly1; check("ht1_raddr", 64'(ht1_raddr), 64'(cur_h1)); end
    if (val_rd) begin pendv = dlyv; vaddr_lat = val_raddr; end
  end

  // Monitor: pops the scoreboard on each result handshake and on each value read.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (val_rd) begin
        if (addr_q.size() == 0) check("unexpected_value_rd", 64'(1), 64'(0));
        else check("value_raddr", 64'(val_raddr), 64'(addr_q.pop_front()));
      end
      if (!result_valid) begin
        first_seen = 1'b0;
      end else if (exp_q.size() == 0) begin
        if (!first_seen) check("unexpected_result", 64'(1), 64'(0));
        first_seen = 1'b1;
      end else begin
        if (!first_seen && exp_q[0].lat != 0) check("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
        first_seen = 1'b1;
        if (result_ready) begin
          e = exp_q.pop_front();
          check("result_hit", 64'(result_hit), 64'(e.hit));
          check("result_value", result_value, e.value);
          first_seen = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin tick(); n++; end
    if (done_cnt < target) check("result_timeout", 64'(done_cnt), 64'(target));
  endtask

  task automatic issue(input logic [31:0] key, input logic [9:0] h0, input logic [9:0] h1);
    int n = 0;
    lookup_valid = 1'b1;
    lookup_key   = key;
    lookup_hash0 = h0;
    lookup_hash1 = h1;
    cur_h0 = h0;
    cur_h1 = h1;
    while (!lookup_ready && n < 50) begin tick(); n++; end
    if (!lookup_ready) check("ready_timeout", 64'(0), 64'(1));
    acc_cyc = cyc;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] key, input logic [9:0] h0, input logic [9:0] h1,
                        input logic [191:0] b0, input logic [191:0] b1, input int d0, input int d1,
                        input logic exp_hit, input logic [7:0] exp_addr, input int lat);
    int start;
    mem_b0 = b0;
    mem_b1 = b1;
    dly0 = d0;
    dly1 = d1;
    dlyv = 1;
    exp_q.push_back('{exp_hit, exp_hit ? val_of(exp_addr) : 64'h0, lat});
    if (exp_hit) addr_q.push_back(exp_addr);
    start = done_cnt;
    issue(key, h0, h1);
    wait_done(start + 1);
    tick();
  endtask

  localparam logic [31:0] K1 = 32'h1234_5678;
  localparam logic [31:0] K3 = 32'h0BAD_F00D;
  localparam logic [31:0] K4 = 32'h4444_0000;

  initial begin
    logic [191:0] b;
    logic [191:0] c;
    int n;
    int start;
    rst = 1'b1;
    lookup_valid = 1'b0;
    lookup_key = '0;
    lookup_hash0 = '0;
    lookup_hash1 = '0;
    result_ready = 1'b1;
    ht0_ack = 1'b0; ht1_ack = 1'b0; val_ack = 1'b0;
    ht0_rdata = '0; ht1_rdata = '0; val_rdata = '0;
    mem_b0 = '0; mem_b1 = '0; cur_h0 = '0; cur_h1 = '0;
    repeat (3) tick();
    rst = 1'b0;

    check("reset_result_valid", 64'(result_valid), 64'(0));
    check("reset_result_hit", 64'(result_hit), 64'(0));
    check("reset_result_value", result_value, 64'h0);
    check("reset_ht_rd", 64'({ht0_rd, ht1_rd, val_rd}), 64'(0));
    tick();
    check("ready_after_reset", 64'(lookup_ready), 64'(1));

    // Hit in bank0 entry 2.
    b = filler(8'h80);
    b[2*48 +: 48] = mk_entry(1'b1, K1, 8'h15);
    lookup(K1, 10'h011, 10'h022, b, filler(8'h90), 1, 1, 1'b1, 8'h15, 6);

    // Absent key.
    lookup(32'hCAFE_BABE, 10'h033, 10'h044, b, filler(8'h90), 1, 1, 1'b0, 8'h00, 4);

    // Bank0 beats bank1.
    b = filler(8'h40);
    b[3*48 +: 48] = mk_entry(1'b1, K3, 8'h07);
    c = filler(8'h50);
    c[0 +: 48] = mk_entry(1'b1, K3, 8'h09);
    lookup(K3, 10'h3FF, 10'h000, b, c, 1, 1, 1'b1, 8'h07, 6);

    // Lowest entry index wins inside a bank.
    b = filler(8'h60);
    b[1*48 +: 48] = mk_entry(1'b1, K3, 8'h21);
    b[3*48 +: 48] = mk_entry(1'b1, K3, 8'h22);
    lookup(K3, 10'h123, 10'h321, b, filler(8'h70), 1, 1, 1'b1, 8'h21, 6);

    // Key present only in entries with valid=0.
    b = filler(8'h10);
    b[0 +: 48] = mk_entry(1'b0, K4, 8'h40);
    c = filler(8'h20);
    c[2*48 +: 48] = mk_entry(1'b0, K4, 8'h41);
    lookup(K4, 10'h0AA, 10'h155, b, c, 1, 1, 1'b0, 8'h00, 4);

    // Bank1 acks five cycles before bank0; hit in bank1.
    c = filler(8'hA0);
    c[1*48 +: 48] = mk_entry(1'b1, K4, 8'h33);
    lookup(K4, 10'h00F, 10'h0F0, filler(8'hB0), c, 6, 1, 1'b1, 8'h33, 11);

    // Bank0 first, bank1 late, miss.
    lookup(32'h5555_AAAA, 10'h001, 10'h002, filler(8'hB0), filler(8'hC0), 1, 4, 1'b0, 8'h00, 7);

    // Downstream stall with a second request waiting.
    b = filler(8'h00);
    b[2*48 +: 48] = mk_entry(1'b1, K1, 8'h15);
    mem_b0 = b; mem_b1 = filler(8'h90); dly0 = 1; dly1 = 1; dlyv = 1;
    result_ready = 1'b0;
    exp_q.push_back('{1'b1, val_of(8'h15), 6});
    addr_q.push_back(8'h15);
    start = done_cnt;
    issue(K1, 10'h2AA, 10'h155);
    lookup_valid = 1'b1;
    lookup_key = 32'h7777_7777;
    n = 0;
    while (!result_valid && n < 50) begin tick(); n++; end
    check("stall_result_valid", 64'(result_valid), 64'(1));
    for (int k = 0; k < 10; k++) begin
      check("stall_lookup_ready", 64'(lookup_ready), 64'(0));
      check("stall_hit", 64'(result_hit), 64'(1));
      check("stall_value", result_value, val_of(8'h15));
      tick();
    end
    exp_q.push_back('{1'b0, 64'h0, 0});
    result_ready = 1'b1;
    tick();
    check("ready_after_handshake", 64'(lookup_ready), 64'(1));
    tick();
    lookup_valid = 1'b0;
    wait_done(start + 2);
    tick();

    // Reset while waiting for the value record; the late ack must be ignored.
    b = filler(8'h00);
    b[0 +: 48] = mk_entry(1'b1, K1, 8'h2C);
    mem_b0 = b; mem_b1 = filler(8'h90); dly0 = 1; dly1 = 1; dlyv = 6;
    addr_q.push_back(8'h2C);
    issue(K1, 10'h00C, 10'h00D);
    n = 0;
    while (!val_rd && n < 50) begin tick(); n++; end
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_result_valid", 64'(result_valid), 64'(0));
    check("rst_result_hit", 64'(result_hit), 64'(0));
    check("rst_result_value", result_value, 64'h0);
    check("rst_val_rd", 64'(val_rd), 64'(0));
`ifdef TUNNEL_LOOKUP_STATS_EN
    check("rst_stat_hit", 64'(stat_hit_cnt), 64'(0));
    check("rst_stat_miss", 64'(stat_miss_cnt), 64'(0));
`endif
    repeat (8) tick();
    check("rst_idle_ready", 64'(lookup_ready), 64'(1));

    // Normal operation after the mid-lookup reset.
    b = filler(8'hE0);
    b[1*48 +: 48] = mk_entry(1'b1, K3, 8'h5A);
    lookup(K3, 10'h2F0, 10'h10F, b, filler(8'hF0), 1, 1, 1'b1, 8'h5A, 6);
`ifdef TUNNEL_LOOKUP_STATS_EN
    check("stat_hit", 64'(stat_hit_cnt), 64'(1));
    check("stat_miss", 64'(stat_miss_cnt), 64'(0));
`endif

    check("exp_queue_empty", 64'(exp_q.size()), 64'(0));
    check("addr_queue_empty", 64'(addr_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
